// File: rtl/bcd_pkg.sv
// Shared types and constants for the BCD-to-binary converter.
// Default sizing, the iteration-count helper and the FSM state type.
package bcd_pkg;

  localparam int unsigned DIGITS_DEF = 5;
  localparam int unsigned BIN_W_DEF  = 16;

  localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;

  typedef enum logic [1:0] {
    StIdle,
    StConv,
    StDone
  } state_e;

  // ceil(log2(10^digits)): shifts needed to move every BCD bit into the accumulator.
  function automatic int unsigned calc_iter(int unsigned digits);
    longint unsigned p;
    p = 1;
    for (int unsigned i = 0; i < digits; i++) begin
      p = p * 10;
    end
    return int'($clog2(p));
  endfunction

endpackage

// File: rtl/bcd_to_bin_if.sv
// Start/busy/done handshake bundle between a BCD source and the converter.
// The master requests conversions; the slave (converter) returns the result.
interface bcd_to_bin_if import bcd_pkg::*; #(
  parameter int unsigned DIGITS = DIGITS_DEF,
  parameter int unsigned BIN_W  = BIN_W_DEF
);

  logic                  start;
  logic [4*DIGITS-1:0]   bcd;
  logic [BIN_W-1:0]      bin;
  logic                  busy;
  logic                  done;
  logic                  ovf;
  logic                  err;

  modport master (
    output start,
    output bcd,
    input  bin,
    input  busy,
    input  done,
    input  ovf,
    input  err
  );

  modport slave (
    input  start,
    input  bcd,
    output bin,
    output busy,
    output done,
    output ovf,
    output err
  );

endinterface

// File: rtl/bcd_digit_adj.sv
// Per-digit correction step of reverse double-dabble.
// A digit that reached 8 or more after the right shift had a borrowed 10 worth 8, so fold it to 5.
module bcd_digit_adj (
  input  logic [3:0] in_i,
  output logic [3:0] out_o
);

  always_comb begin
    out_o = (in_i >= 4'd8) ? (in_i - 4'd3) : in_i;
  end

endmodule

// File: rtl/bcd_to_bin.sv
// Sequential BCD-to-binary converter using reverse double-dabble with a fixed latency.
// Holds the FSM, iteration counter, digit/accumulator shift register and result latch.
module bcd_to_bin import bcd_pkg::*; #(
  parameter int unsigned DIGITS = DIGITS_DEF,
  parameter int unsigned BIN_W  = BIN_W_DEF
) (
  input logic          clk,
  input logic          reset_n,
  bcd_to_bin_if.slave  bus
);

  localparam int unsigned ITER  = calc_iter(DIGITS);
  localparam int unsigned DW    = 4 * DIGITS;
  localparam int unsigned CNT_W = $clog2(ITER + 1);
  localparam logic [CNT_W-1:0] CntLast = CNT_W'(ITER - 1);

  state_e            state_q, state_d;
  logic [DW-1:0]     digits_q, digits_d;
  logic [ITER-1:0]   accum_q, accum_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BIN_W-1:0]  bin_q, bin_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              ovf_q, ovf_d;
  logic              err_q, err_d;

  logic [DW+ITER-1:0] shifted;
  logic [DW-1:0]      digits_adj;
  logic               bad_digit;

  // Digit 0's LSB falls into the accumulator MSB on every shift.
  assign shifted = {digits_q, accum_q} >> 1;

  for (genvar i = 0; i < DIGITS; i++) begin : g_adj
    bcd_digit_adj u_adj (
      .in_i  (shifted[ITER + 4*i +: 4]),
      .out_o (digits_adj[4*i +: 4])
    );
  end

  always_comb begin
    bad_digit = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bus.bcd[4*i +: 4] > BCD_MAX_DIGIT) begin
        bad_digit = 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    digits_d = digits_q;
    accum_d  = accum_q;
    cnt_d    = cnt_q;
    bin_d    = bin_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    ovf_d    = ovf_q;
    err_d    = err_q;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          digits_d = bus.bcd;
          accum_d  = '0;
          cnt_d    = '0;
          bin_d    = '0;
          ovf_d    = 1'b0;
          if (bad_digit) begin
            state_d = StDone;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else begin
            state_d = StConv;
            busy_d  = 1'b1;
            err_d   = 1'b0;
          end
        end
      end
      StConv: begin
        digits_d = digits_adj;
        accum_d  = shifted[ITER-1:0];
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CntLast) begin
          state_d = StDone;
          done_d  = 1'b1;
          // Any set bit above BIN_W means the value does not fit: saturate.
          if (|shifted[ITER-1:BIN_W]) begin
            bin_d = '1;
            ovf_d = 1'b1;
          end else begin
            bin_d = shifted[BIN_W-1:0];
            ovf_d = 1'b0;
          end
        end else begin
          busy_d = 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      digits_q <= '0;
      accum_q  <= '0;
      cnt_q    <= '0;
      bin_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      digits_q <= digits_d;
      accum_q  <= accum_d;
      cnt_q    <= cnt_d;
      bin_q    <= bin_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      ovf_q    <= ovf_d;
      err_q    <= err_d;
    end
  end

  assign bus.bin  = bin_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.ovf  = ovf_q;
  assign bus.err  = err_q;

endmodule

// File: tb/tb_bcd_to_bin.sv
// Self-checking bench for bcd_to_bin: directed scenarios plus random conversions
// compared against a decimal-arithmetic reference model.
module tb_bcd_to_bin;

  logic clk;
  logic reset_n;
  int   errors;
  int   checks;

  bcd_to_bin_if bus ();

  bcd_to_bin u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: {err, ovf, bin} from decimal value of the digits.
  function automatic logic [17:0] model(logic [19:0] v);
    int unsigned val;
    int unsigned mult;
    int unsigned d;
    val  = 0;
    mult = 1;
    for (int i = 0; i < 5; i++) begin
      d = 32'(v[4*i +: 4]);
      if (d > 9) return {1'b1, 1'b0, 16'h0000};
      val  = val + d * mult;
      mult = mult * 10;
    end
    if (val > 65535) return {1'b0, 1'b1, 16'hFFFF};
    return {2'b00, val[15:0]};
  endfunction

  // Called at a negedge with the DUT idle; issues one start and waits for done.
  task automatic run_one(input logic [19:0] v, output int done_cyc, output int busy_cnt,
                         output int overlap, output logic [15:0] b, output logic o,
                         output logic e);
    done_cyc = -1;
    busy_cnt = 0;
    overlap  = 0;
    b = '0;
    o = 1'b0;
    e = 1'b0;
    bus.bcd   = v;
    bus.start = 1'b1;
    for (int c = 1; c <= 40 && done_cyc < 0; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.busy) busy_cnt++;
      if (bus.busy && bus.done) overlap++;
      if (bus.done) begin
        done_cyc = c;
        b = bus.bin;
        o = bus.ovf;
        e = bus.err;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    bus.start = 1'b0;
    bus.bcd   = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.bin !== 16'h0) begin
      errors++; $display("FAIL reset_bin: got %h want 0000", bus.bin);
    end
    checks++;
    if ({bus.busy, bus.done, bus.ovf, bus.err} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: got busy/done/ovf/err=%b want 0000",
               {bus.busy, bus.done, bus.ovf, bus.err});
    end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int dc, bc, ov;
    logic [15:0] b;
    logic o, e;
    run_one(20'h12345, dc, bc, ov, b, o, e);
    checks++;
    if (dc !== 18) begin errors++; $display("FAIL basic_latency: got %0d want 18", dc); end
    checks++;
    if (bc !== 17) begin errors++; $display("FAIL basic_busy_cycles: got %0d want 17", bc); end
    checks++;
    if (ov !== 0) begin errors++; $display("FAIL basic_busy_done_overlap: got %0d want 0", ov); end
    checks++;
    if ({e, o, b} !== {2'b00, 16'h3039}) begin
      errors++; $display("FAIL basic_result: got err=%b ovf=%b bin=%h want 0 0 3039", e, o, b);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (bus.bin !== 16'h3039 || bus.done !== 1'b0) begin
      errors++; $display("FAIL basic_hold: got bin=%h done=%b want 3039 0", bus.bin, bus.done);
    end
  endtask

  task automatic test_bounds();
    logic [19:0] tbl [4];
    logic [17:0] exp_r [4];
    int dc, bc, ov;
    logic [15:0] b;
    logic o, e;
    tbl[0] = 20'h00000; exp_r[0] = {2'b00, 16'h0000};
    tbl[1] = 20'h65535; exp_r[1] = {2'b00, 16'hFFFF};
    tbl[2] = 20'h65536; exp_r[2] = {2'b01, 16'hFFFF};
    tbl[3] = 20'h99999; exp_r[3] = {2'b01, 16'hFFFF};
    for (int i = 0; i < 4; i++) begin
      run_one(tbl[i], dc, bc, ov, b, o, e);
      checks++;
      if ({e, o, b} !== exp_r[i] || dc !== 18) begin
        errors++;
        $display("FAIL bounds_%h: got err/ovf/bin=%b/%b/%h at cyc %0d want %h at cyc 18",
                 tbl[i], e, o, b, dc, exp_r[i]);
      end
    end
  endtask

  task automatic test_invalid();
    int dc, bc, ov;
    logic [15:0] b;
    logic o, e;
    run_one(20'h0A000, dc, bc, ov, b, o, e);
    checks++;
    if (dc !== 1) begin errors++; $display("FAIL invalid_latency: got %0d want 1", dc); end
    checks++;
    if (bc !== 0) begin errors++; $display("FAIL invalid_busy: got %0d want 0", bc); end
    checks++;
    if ({e, o, b} !== {2'b10, 16'h0000}) begin
      errors++; $display("FAIL invalid_result: got err=%b ovf=%b bin=%h want 1 0 0000", e, o, b);
    end
    run_one(20'h00777, dc, bc, ov, b, o, e);
    checks++;
    if ({e, o, b} !== {2'b00, 16'd777} || dc !== 18) begin
      errors++;
      $display("FAIL invalid_then_valid: got err=%b ovf=%b bin=%0d cyc=%0d want 0 0 777 18",
               e, o, b, dc);
    end
  endtask

  task automatic test_ignore_start();
    int n_done, done_at;
    logic [15:0] b;
    n_done  = 0;
    done_at = -1;
    b = '0;
    bus.bcd   = 20'h12345;
    bus.start = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (c == 5) begin
        bus.start = 1'b1;
        bus.bcd   = 20'h00001;
      end
      if (bus.done) begin
        n_done++;
        done_at = c;
        b = bus.bin;
      end
    end
    checks++;
    if (n_done !== 1 || done_at !== 18) begin
      errors++; $display("FAIL ignore_done_count: got %0d at cyc %0d want 1 at 18", n_done, done_at);
    end
    checks++;
    if (b !== 16'h3039) begin
      errors++; $display("FAIL ignore_result: got %h want 3039", b);
    end
  endtask

  task automatic test_back_to_back();
    int d1, d2;
    logic [15:0] b1, b2;
    d1 = -1;
    d2 = -1;
    b1 = '0;
    b2 = '0;
    bus.bcd   = 20'h00255;
    bus.start = 1'b1;
    for (int c = 1; c <= 60 && d2 < 0; c++) begin
      @(negedge clk);
      if (bus.done) begin
        if (d1 < 0) begin
          d1 = c;
          b1 = bus.bin;
          bus.bcd = 20'h01000;
        end else begin
          d2 = c;
          b2 = bus.bin;
          bus.start = 1'b0;
        end
      end
    end
    bus.start = 1'b0;
    @(negedge clk);
    checks++;
    if (d1 !== 18 || d2 - d1 !== 19) begin
      errors++; $display("FAIL b2b_spacing: got first=%0d gap=%0d want 18 19", d1, d2 - d1);
    end
    checks++;
    if (b1 !== 16'd255 || b2 !== 16'd1000) begin
      errors++; $display("FAIL b2b_results: got %0d,%0d want 255,1000", b1, b2);
    end
  endtask

  task automatic test_reset_mid();
    int dc, bc, ov, stray;
    logic [15:0] b;
    logic o, e;
    stray = 0;
    bus.bcd   = 20'h54321;
    bus.start = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++; $display("FAIL midreset_pre_busy: got %b want 1", bus.busy);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.ovf, bus.err} !== 4'b0000 || bus.bin !== 16'h0) begin
      errors++;
      $display("FAIL midreset_outputs: got busy/done/ovf/err=%b bin=%h want 0000 0000",
               {bus.busy, bus.done, bus.ovf, bus.err}, bus.bin);
    end
    repeat (3) begin
      @(negedge clk);
      if (bus.done) stray++;
    end
    reset_n = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (bus.done || bus.busy) stray++;
    end
    checks++;
    if (stray !== 0) begin
      errors++; $display("FAIL midreset_stray_activity: got %0d cycles want 0", stray);
    end
    run_one(20'h00042, dc, bc, ov, b, o, e);
    checks++;
    if ({e, o, b} !== {2'b00, 16'd42} || dc !== 18) begin
      errors++; $display("FAIL midreset_recover: got bin=%0d cyc=%0d want 42 18", b, dc);
    end
  endtask

  task automatic test_random();
    logic [19:0] v;
    logic [17:0] exp_r;
    int dc, bc, ov, pos;
    logic [15:0] b;
    logic o, e;
    for (int n = 0; n < 30; n++) begin
      for (int d = 0; d < 5; d++) v[4*d +: 4] = 4'($urandom_range(0, 9));
      if ($urandom_range(0, 5) == 0) begin
        pos = int'($urandom_range(0, 4));
        v[4*pos +: 4] = 4'($urandom_range(10, 15));
      end
      exp_r = model(v);
      run_one(v, dc, bc, ov, b, o, e);
      checks++;
      if ({e, o, b} !== exp_r || dc !== (exp_r[17] ? 1 : 18) || ov !== 0) begin
        errors++;
        $display("FAIL random_%h: got err/ovf/bin=%b/%b/%h cyc=%0d want %h cyc=%0d",
                 v, e, o, b, dc, exp_r, exp_r[17] ? 1 : 18);
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_basic();
    test_bounds();
    test_invalid();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
